// File: rtl/piso_framer.sv
// piso_framer -- parametrised parallel-to-serial framer.
//
// Captures a DATA_W-bit word through a ready/load handshake and sends it on
// one line as a frame: start bit (1), data bits (MSB or LSB first), optional
// even parity bit, stop bit (0). Each serial bit lasts BIT_DIV clocks.
// Back-to-back frames are supported: a load accepted in the last STOP cycle
// starts the next frame with no idle cycle in between.
//
// Optional feature macro: PISO_FRAMER_PARITY_EN (adds the PARITY state).
//
// Parameters:
//   DATA_W    data bits per frame (>= 1)
//   BIT_DIV   clocks per serial bit (>= 1)
//   MSB_FIRST 1: data_in[DATA_W-1] sent first, 0: data_in[0] sent first
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   load      request to send data_in, accepted only while ready=1
//   data_in   word to send, sampled on the accepting edge only
//   data_out  serial line (idle 0, start 1, stop 0), registered
//   ready     block accepts a word this cycle (combinational from state)
//   busy      frame in progress, registered
//   done      one-cycle pulse when a stop bit completes, registered
//
// States:
//   state  | meaning
//   IDLE   | line idle at 0, waiting for load
//   START  | start bit (1) on the line
//   DATA   | data bits, bit_cnt counts 0..DATA_W-1
//   PARITY | even parity of the captured word (PISO_FRAMER_PARITY_EN only)
//   STOP   | stop bit (0); last cycle may accept the next word

module piso_framer #(
    parameter int DATA_W    = 8,
    parameter int BIT_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef PISO_FRAMER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
    } state_t;
`endif

    state_t              state;
    logic [DATA_W-1:0]   shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                bit_end;
    logic                first_bit;
    logic [DATA_W-1:0]   shreg_next;

`ifdef PISO_FRAMER_PARITY_EN
    // Parity is latched at capture so later changes on data_in cannot leak in.
    logic                parity_bit;
`endif

    assign bit_end = (div_cnt == DIV_LAST);

    // The next bit to transmit always sits at the "front" of the shift
    // register; after it is sent the register moves one place toward it.
    assign first_bit  = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
    assign shreg_next = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

    always_comb begin
        ready = (state == IDLE) || ((state == STOP) && bit_end);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            data_out   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_FRAMER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            if (state != IDLE) begin
                div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        state      <= START;
                        shreg      <= data_in;
                        data_out   <= 1'b1;
                        busy       <= 1'b1;
                        div_cnt    <= '0;
`ifdef PISO_FRAMER_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                    end
                end

                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        data_out <= first_bit;
                        shreg    <= shreg_next;
                        bit_cnt  <= '0;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == CNT_LAST) begin
`ifdef PISO_FRAMER_PARITY_EN
                            state    <= PARITY;
                            data_out <= parity_bit;
`else
                            state    <= STOP;
                            data_out <= 1'b0;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            data_out <= first_bit;
                            shreg    <= shreg_next;
                        end
                    end
                end

`ifdef PISO_FRAMER_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        data_out <= 1'b0;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        done <= 1'b1;
                        // ready is high here, so a load chains straight into
                        // the next start bit without an idle cycle.
                        if (load) begin
                            state      <= START;
                            shreg      <= data_in;
                            data_out   <= 1'b1;
`ifdef PISO_FRAMER_PARITY_EN
                            parity_bit <= ^data_in;
`endif
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            data_out <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    data_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_framer.sv
// Testbench for piso_framer: two instances (MSB first / BIT_DIV=1 and
// LSB first / BIT_DIV=3). Expected serial streams are queued when a word is
// issued; per-instance monitors collect the line while busy and compare on
// each done pulse.

module tb_piso_framer;

`ifdef PISO_FRAMER_PARITY_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic clk;
    logic rst;
    logic load0, load1;
    logic [7:0] data0, data1;
    logic data_out0, ready0, busy0, done0;
    logic data_out1, ready1, busy1, done1;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [63:0] stream;
        int          len;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [63:0] col0, col1;
    int          n0, n1;

    piso_framer #(.DATA_W(8), .BIT_DIV(1), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .load(load0), .data_in(data0),
        .data_out(data_out0), .ready(ready0), .busy(busy0), .done(done0)
    );

    piso_framer #(.DATA_W(8), .BIT_DIV(3), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .data_in(data1),
        .data_out(data_out1), .ready(ready1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // dbits: data bits in transmission order (bit 7 goes out first).
    function automatic exp_t make_exp(input logic [7:0] dbits, input logic par,
                                      input int div, input int acc);
        exp_t        e;
        logic [11:0] fb;
        int          nb;
        if (PE != 0) begin
            fb = {1'b0, 1'b1, dbits, par, 1'b0};
            nb = 11;
        end else begin
            fb = {2'b00, 1'b1, dbits, 1'b0};
            nb = 10;
        end
        e.stream = '0;
        for (int i = nb - 1; i >= 0; i--)
            for (int j = 0; j < div; j++)
                e.stream = {e.stream[62:0], fb[i]};
        e.len = nb * div;
        e.acc = acc;
        return e;
    endfunction

    task automatic send0(input logic [7:0] w, input logic [7:0] dbits, input logic par);
        int t = 0;
        @(negedge clk);
        while (!ready0 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("dut0 ready timeout", 1, 0);
        load0 = 1'b1;
        data0 = w;
        q0.push_back(make_exp(dbits, par, 1, cyc + 1));
        @(posedge clk);
        #1;
        load0 = 1'b0;
        data0 = ~w;
    endtask

    task automatic send1(input logic [7:0] w, input logic [7:0] dbits, input logic par);
        int t = 0;
        @(negedge clk);
        while (!ready1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("dut1 ready timeout", 1, 0);
        load1 = 1'b1;
        data1 = w;
        q1.push_back(make_exp(dbits, par, 3, cyc + 1));
        @(posedge clk);
        #1;
        load1 = 1'b0;
        data1 = ~w;
    endtask

    task automatic drain;
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("drain timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle(input string name);
        chk({name, " dut0 idle"}, {data_out0, ready0, busy0, done0}, 4'b0100);
        chk({name, " dut1 idle"}, {data_out1, ready1, busy1, done1}, 4'b0100);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            col0 = '0;
            n0   = 0;
        end else begin
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("dut0 unexpected done", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("dut0 stream", col0, e.stream);
                    chk("dut0 busy cycles", n0, e.len);
                    chk("dut0 done latency", cyc - e.acc, e.len);
                end
                col0 = '0;
                n0   = 0;
            end
            if (busy0) begin
                col0 = {col0[62:0], data_out0};
                n0++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            col1 = '0;
            n1   = 0;
        end else begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("dut1 unexpected done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("dut1 stream", col1, e.stream);
                    chk("dut1 busy cycles", n1, e.len);
                    chk("dut1 done latency", cyc - e.acc, e.len);
                end
                col1 = '0;
                n1   = 0;
            end
            if (busy1) begin
                col1 = {col1[62:0], data_out1};
                n1++;
            end
        end
    end

    initial begin
        rst   = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        data0 = '0;
        data1 = '0;

        // Reset held 3 cycles, then idle with no load.
        repeat (3) begin
            @(negedge clk);
            chk_idle("in reset");
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk_idle("after reset");
        end

        // Single MSB-first frame: 1,1,0,1,0,0,1,0,1,0.
        send0(8'hA5, 8'b10100101, 1'b0);
        drain();

        // LSB first, BIT_DIV=3.
        send1(8'h01, 8'b10000000, 1'b1);
        drain();
        send1(8'h07, 8'b11100000, 1'b1);
        drain();

        // Back-to-back frames with an ignored load in between.
        send0(8'hFF, 8'b11111111, 1'b0);
        repeat (4) @(negedge clk);
        chk("ready low mid-frame", ready0, 1'b0);
        load0 = 1'b1;
        data0 = 8'h00;
        @(posedge clk);
        #1;
        load0 = 1'b0;
        send0(8'h3C, 8'b00111100, 1'b0);
        chk("b2b done+start same edge", {done0, data_out0, busy0}, 3'b111);
        drain();

        // Parity vectors (parity bit only framed when enabled).
        send0(8'h07, 8'b00000111, 1'b1);
        drain();
        send0(8'h03, 8'b00000011, 1'b0);
        drain();

        // Reset during data bit 4 of 8'hA5.
        send0(8'hA5, 8'b10100101, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        chk("busy before abort", busy0, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort outputs", {data_out0, ready0, busy0, done0}, 4'b0100);
        q0.delete();
        repeat (2) @(negedge clk);
        chk_idle("abort held");
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("abort released");
        end
        send0(8'hA5, 8'b10100101, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/piso_framer.md
Name: piso_framer

Overview:
- Parametrised parallel-to-serial framer. Successor to the fixed 8-bit serializer.
- Captures a DATA_W-bit word through a ready/load handshake and emits it on a single line as one frame: start bit, data bits in configurable order, optional parity, stop bit.
- Each bit is held for BIT_DIV clocks.
- Sits between the word-producing logic and the serial link driver. Supports back-to-back frames with no idle gap.

Parameters:
- DATA_W, 8: data bits per frame, >= 1.
- BIT_DIV, 1: clocks per serial bit, >= 1.
- MSB_FIRST, 1: 1 sends data_in[DATA_W-1] first; 0 sends data_in[0] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- load  input  1  request to send data_in; accepted only when ready=1.
- data_in  input  DATA_W  word to send; sampled on the accepting edge only.
- data_out  output  1  serial line. Idle level 0, start bit 1, stop bit 0.
- ready  output  1  block can accept a word this cycle.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset is asynchronous, active-low. While rst=0 and on release:
  - state=IDLE, shift register=0, bit counter=0, divider=0.
  - data_out=0, ready=1, busy=0, done=0.
- Reset mid-frame aborts the frame immediately. No done pulse is produced.
- States: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP. All outputs are registered except ready.
- IDLE:
  - data_out=0.
  - On load=1 at edge k: capture data_in and go to START.
  - From edge k, data_out=1 for BIT_DIV cycles.
- Divider counts 0..BIT_DIV-1 in every non-IDLE state. The state/bit advances only on the edge where divider==BIT_DIV-1; the divider then wraps to 0.
- START -> DATA. data_out then carries data bit 0 of the order (MSB or LSB per MSB_FIRST).
- DATA:
  - Bit counter runs 0..DATA_W-1.
  - After the last data bit, go to PARITY if enabled, else STOP.
- PARITY -> STOP.
- STOP:
  - data_out=0 for BIT_DIV cycles.
  - On the final STOP edge, done=1 for exactly one cycle.
  - Next state is IDLE, or START if load was accepted that cycle.
- ready = (state==IDLE) || (state==STOP && divider==BIT_DIV-1). This is combinational from state.
- Back-to-back frames:
  - load=1 in the last STOP cycle captures the new word.
  - done pulses and data_out goes to 1 (start) on the same edge, so there is no idle cycle between frames.
- load while ready=0: ignored. The frame in progress is unaffected and data_in is not captured.
- Frame length L = (DATA_W + 2 + P) * BIT_DIV clocks, where P=1 with PARITY_EN, else 0.
  - From the accepting edge k, done is high in the cycle after edge k+L.
  - busy is high for L cycles.
- Arithmetic:
  - Divider width is clog2(BIT_DIV), minimum 1.
  - Bit counter width is clog2(DATA_W), minimum 1.
  - No overflow is possible: both counters wrap only by explicit compare.

Optional Feature:
- Macro: PISO_FRAMER_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP. It carries even parity, i.e. the XOR of the captured DATA_W bits, computed from the captured word and not from live data_in. Frame length is DATA_W+3 bits.
- Undefined: no PARITY state or parity logic. Frame length is DATA_W+2 bits and DATA goes directly to STOP.

Test Plan:
- Reset then idle (DATA_W=8, BIT_DIV=1): hold rst=0 for 3 cycles, release, no load. Expect data_out=0, ready=1, busy=0, done=0 throughout.
- Single frame, MSB_FIRST=1, BIT_DIV=1, no parity: load 8'hA5 at edge 0. Expect data_out sequence from edge 0: 1,1,0,1,0,0,1,0,1,0. Expect done high for one cycle after edge 10, and busy high for 10 cycles.
- LSB first with divider (MSB_FIRST=0, BIT_DIV=3): send 8'h01. Expect data_out = 1 held 3 cycles (start), then 1 held 3 cycles, then 0 for 21 cycles, then 0 stop held 3 cycles. Expect done after 30 cycles.
- Back-to-back and ignored load (BIT_DIV=1):
  - Pulse load with 8'hFF at edge 0.
  - Pulse load with 8'h00 at edge 4; it is ignored (ready=0).
  - Hold load=1 with 8'h3C at the last STOP cycle.
  - Expect done and the start bit of 8'h3C on the same edge, with no idle cycle between frames. Expect a second done 10 cycles later.
- Parity (PISO_FRAMER_PARITY_EN defined):
  - 8'h07 gives parity bit 1. 8'h03 gives parity bit 0.
  - Frame is 11 bits, and done arrives 11*BIT_DIV cycles after load.
  - Change data_in after acceptance; parity must be unchanged.
- Reset mid-frame: assert rst=0 during data bit 4 of 8'hA5. Expect data_out=0, busy=0, ready=1 immediately, with no clock edge needed, and no done pulse. A new load after release sends a complete correct frame.
